// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus layouts and load-type indices shared by the memory stage
package mem_stage_pkg;

    // ld_inst one-hot bit positions
    localparam int LD_W  = 0;
    localparam int LD_B  = 1;
    localparam int LD_H  = 2;
    localparam int LD_BU = 3;
    localparam int LD_HU = 4;

    // Exception / ertn / interrupt flags carried alongside each instruction
    typedef struct packed {
        logic sys;
        logic brk;
        logic ine;
        logic pc;
        logic mem;
        logic ertn;
        logic intr;
        logic invtlb_op;
    } exc_flags_t;

    // CSR-related fields carried alongside each instruction
    typedef struct packed {
        logic        csr_we;
        logic        csr_gr;
        logic        tlbrd;
        logic [13:0] csr_num;
    } csr_fields_t;

    typedef struct packed {
        exc_flags_t  exc;
        csr_fields_t csr;
        logic [4:0]  ld_inst;
        logic        res_from_mem;
        logic        mem_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        exc_flags_t  exc;
        csr_fields_t csr;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        ld_pending;
        logic        csr_gr;
        logic [13:0] csr_num;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_to_ds_t;

    typedef struct packed {
        logic        tlbrd;
        logic [13:0] csr_num;
        logic        csr_gr;
    } ms_to_es_t;

    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);
    localparam int MS_TO_DS_BUS_WD = $bits(ms_to_ds_t);
    localparam int MS_TO_ES_BUS_WD = $bits(ms_to_es_t);

endpackage

// File: rtl/mem_ld_align.sv
// rtl/mem_ld_align.sv - selects and extends the addressed byte/half/word of load data
module mem_ld_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_inst,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then sign- or zero-extend by load type; plain word is the fallback
    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        if (ld_inst[LD_B])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_inst[LD_H])
            result = {{16{half_sel[15]}}, half_sel};
        else if (ld_inst[LD_BU])
            result = {24'd0, byte_sel};
        else if (ld_inst[LD_HU])
            result = {16'd0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage; MS_LD_FWD_EN enables early load forwarding to ID
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DISCARD_CNT_W = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
    output logic                       ms_ex_int,
    input  logic                       ws_block
);

    es_to_ms_t                ms_r;
    logic                     ms_valid;
    logic                     data_ok_r;
    logic [31:0]              rdata_r;
    logic [DISCARD_CNT_W-1:0] discard_cnt;

    logic        req_sent;
    logic        resp_hit;
    logic        ms_ready_go;
    logic        disc_inc;
    logic        disc_dec;
    logic [31:0] rdata_sel;
    logic [31:0] ld_result;
    logic [31:0] final_result;
    logic        ld_pending;

    ms_to_ws_t ws_o;
    ms_to_ds_t ds_o;
    ms_to_es_t es_o;

    // A response only belongs to the current instruction once all stale ones are drained
    assign req_sent       = (ms_r.res_from_mem | ms_r.mem_we) & ~ms_r.exc.mem;
    assign resp_hit       = data_sram_data_ok & (discard_cnt == '0);
    assign ms_ready_go    = ~req_sent | data_ok_r | resp_hit;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    // Flushed instruction still owes a response; a response while draining is swallowed
    assign disc_inc = ws_block & ms_valid & req_sent & ~data_ok_r & ~resp_hit;
    assign disc_dec = data_sram_data_ok & (discard_cnt != '0);

    assign rdata_sel    = data_ok_r ? rdata_r : data_sram_rdata;
    assign final_result = ms_r.res_from_mem ? ld_result : ms_r.result;

    mem_ld_align u_ld_align (
        .ld_inst (ms_r.ld_inst),
        .addr    (ms_r.result[1:0]),
        .rdata   (rdata_sel),
        .result  (ld_result)
    );

`ifdef MS_LD_FWD_EN
    assign ld_pending = ms_valid & ms_r.res_from_mem & ~ms_ready_go;
`else
    assign ld_pending = ms_valid & ms_r.res_from_mem;
`endif

    // Stage valid and payload; a WB flush kills both the resident and any incoming instruction
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            ms_r     <= '0;
        end else begin
            if (ws_block)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (es_to_ms_valid & ms_allowin)
                ms_r <= es_to_ms_bus;
        end
    end

    // Hold a response that arrived while WB was stalled until the instruction moves on
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok_r <= 1'b0;
            rdata_r   <= 32'd0;
        end else if (ws_block | (ms_to_ws_valid & ws_allowin)) begin
            data_ok_r <= 1'b0;
        end else if (resp_hit & ms_valid & req_sent & ~ws_allowin) begin
            data_ok_r <= 1'b1;
            rdata_r   <= data_sram_rdata;
        end
    end

    // Count responses still owed to flushed instructions, saturating at the counter maximum
    always_ff @(posedge clk) begin
        if (!resetn)
            discard_cnt <= '0;
        else if (disc_inc & ~disc_dec & (discard_cnt != '1))
            discard_cnt <= discard_cnt + DISCARD_CNT_W'(1);
        else if (disc_dec & ~disc_inc)
            discard_cnt <= discard_cnt - DISCARD_CNT_W'(1);
    end

    assign ms_ex_int = ms_valid & (|ms_r.exc);

    assign ws_o.exc          = ms_r.exc;
    assign ws_o.csr          = ms_r.csr;
    assign ws_o.gr_we        = ms_r.gr_we;
    assign ws_o.dest         = ms_r.dest;
    assign ws_o.final_result = final_result;
    assign ws_o.pc           = ms_r.pc;

    assign ds_o.ld_pending = ld_pending;
    assign ds_o.csr_gr     = ms_valid & ms_r.csr.csr_gr;
    assign ds_o.csr_num    = ms_r.csr.csr_num;
    assign ds_o.we         = ms_valid & ms_r.gr_we;
    assign ds_o.dest       = ms_r.dest;
    assign ds_o.result     = final_result;

    assign es_o.tlbrd   = ms_valid & ms_r.csr.tlbrd;
    assign es_o.csr_num = ms_r.csr.csr_num;
    assign es_o.csr_gr  = ms_valid & ms_r.csr.csr_gr;

    assign ms_to_ws_bus = ws_o;
    assign ms_to_ds_bus = ds_o;
    assign ms_to_es_bus = es_o;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       resetn;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus;
    logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus;
    logic                       ms_ex_int;
    logic                       ws_block;

    ms_to_ws_t ws_s;
    ms_to_ds_t ds_s;
    ms_to_es_t es_s;
    assign ws_s = ms_to_ws_bus;
    assign ds_s = ms_to_ds_bus;
    assign es_s = ms_to_es_bus;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ds_bus      (ms_to_ds_bus),
        .ms_to_es_bus      (ms_to_es_bus),
        .ms_ex_int         (ms_ex_int),
        .ws_block          (ws_block)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic es_to_ms_t mk_inst(input logic [4:0] ld_inst, input logic rfm, input logic we,
                                          input logic exc_mem, input logic exc_ine, input logic [31:0] res,
                                          input logic [4:0] dest);
        es_to_ms_t t;
        t = '0;
        t.ld_inst      = ld_inst;
        t.res_from_mem = rfm;
        t.mem_we       = we;
        t.exc.mem      = exc_mem;
        t.exc.ine      = exc_ine;
        t.gr_we        = ~we;
        t.dest         = dest;
        t.result       = res;
        t.pc           = 32'h1c00_0000 + res;
        return t;
    endfunction

    task automatic test_reset();
        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0; ws_block = 1'b0;
        tick(); tick();
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ws_valid got %b exp 0", ms_to_ws_valid); end
        n_checks++; if (ms_ex_int !== 1'b0) begin n_fail++; $display("FAIL rst_ex_int got %b exp 0", ms_ex_int); end
        n_checks++; if (ms_allowin !== 1'b1) begin n_fail++; $display("FAIL rst_allowin got %b exp 1", ms_allowin); end
        n_checks++; if (ds_s.we !== 1'b0 || ds_s.ld_pending !== 1'b0 || ds_s.csr_gr !== 1'b0) begin n_fail++; $display("FAIL rst_ds_bits got we=%b lp=%b gr=%b exp 0", ds_s.we, ds_s.ld_pending, ds_s.csr_gr); end
        n_checks++; if (es_s.csr_gr !== 1'b0 || es_s.tlbrd !== 1'b0) begin n_fail++; $display("FAIL rst_es_bits got gr=%b tlbrd=%b exp 0", es_s.csr_gr, es_s.tlbrd); end
        n_checks++; if (dut.discard_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_discard got %0d exp 0", dut.discard_cnt); end
        resetn = 1'b1;
    endtask

    task automatic test_ld_w();
        logic exp_lp;
`ifdef MS_LD_FWD_EN
        exp_lp = 1'b0;
`else
        exp_lp = 1'b1;
`endif
        tick();
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000, 5'd5);
        tick();
        es_to_ms_valid = 1'b0; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ldw_wait_valid got %b exp 0", ms_to_ws_valid); end
        n_checks++; if (ms_allowin !== 1'b0) begin n_fail++; $display("FAIL ldw_wait_allowin got %b exp 0", ms_allowin); end
        n_checks++; if (ds_s.ld_pending !== 1'b1 || ds_s.we !== 1'b1) begin n_fail++; $display("FAIL ldw_wait_ds got lp=%b we=%b exp 1 1", ds_s.ld_pending, ds_s.we); end
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1) begin n_fail++; $display("FAIL ldw_valid got %b exp 1", ms_to_ws_valid); end
        n_checks++; if (ws_s.final_result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ldw_result got %h exp deadbeef", ws_s.final_result); end
        n_checks++; if (ds_s.result !== 32'hDEAD_BEEF || ds_s.dest !== 5'd5) begin n_fail++; $display("FAIL ldw_ds_fwd got %h/%0d exp deadbeef/5", ds_s.result, ds_s.dest); end
        n_checks++; if (ds_s.ld_pending !== exp_lp) begin n_fail++; $display("FAIL ldw_ld_pending got %b exp %b", ds_s.ld_pending, exp_lp); end
        tick();
        data_sram_data_ok = 1'b0; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL ldw_after_valid got %b exp 0", ms_to_ws_valid); end
    endtask

    task automatic test_ld_align();
        logic [4:0]  li  [5] = '{5'b00010, 5'b10000, 5'b00100, 5'b01000, 5'b00010};
        logic [31:0] ad  [5] = '{32'h1002, 32'h1002, 32'h1002, 32'h1003, 32'h1001};
        logic [31:0] rd  [5] = '{32'h0080_0000, 32'h8001_0000, 32'h8001_0000, 32'h9A00_0000, 32'h0000_7F00};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_009A, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(li[i], 1'b1, 1'b0, 1'b0, 1'b0, ad[i], 5'd7);
            tick();
            es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = rd[i]; #1;
            n_checks++; if (ms_to_ws_valid !== 1'b1 || ws_s.final_result !== exp[i]) begin n_fail++; $display("FAIL align_%0d got v=%b %h exp 1 %h", i, ms_to_ws_valid, ws_s.final_result, exp[i]); end
            tick();
            data_sram_data_ok = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 5'd1);
        tick();
        es_to_ms_bus = mk_inst(5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5A5A_0002, 5'd2); #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ws_s.final_result !== 32'hA5A5_0001 || ms_allowin !== 1'b1) begin n_fail++; $display("FAIL b2b_first got v=%b %h a=%b exp 1 a5a50001 1", ms_to_ws_valid, ws_s.final_result, ms_allowin); end
        tick();
        es_to_ms_valid = 1'b0; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ws_s.final_result !== 32'h5A5A_0002 || ws_s.dest !== 5'd2) begin n_fail++; $display("FAIL b2b_second got v=%b %h d=%0d exp 1 5a5a0002 2", ms_to_ws_valid, ws_s.final_result, ws_s.dest); end
        tick();
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", ms_to_ws_valid); end
    endtask

    task automatic test_buffer();
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 5'd9);
        tick();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin n_fail++; $display("FAIL buf_arrive got v=%b a=%b exp 1 0", ms_to_ws_valid, ms_allowin); end
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hFFFF_FFFF; #1;
        n_checks++; if (dut.data_ok_r !== 1'b1) begin n_fail++; $display("FAIL buf_data_ok_r got %b exp 1", dut.data_ok_r); end
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ws_s.final_result !== 32'h1234_5678) begin n_fail++; $display("FAIL buf_held got v=%b %h exp 1 12345678", ms_to_ws_valid, ws_s.final_result); end
        ws_allowin = 1'b1;
        tick();
        n_checks++; if (dut.data_ok_r !== 1'b0 || ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL buf_clear got ok_r=%b v=%b exp 0 0", dut.data_ok_r, ms_to_ws_valid); end
    endtask

    task automatic test_discard();
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h4000, 5'd3);
        tick();
        es_to_ms_valid = 1'b0; ws_block = 1'b1;
        tick();
        ws_block = 1'b0; es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 5'd4); #1;
        n_checks++; if (dut.discard_cnt !== 2'd1 || ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL disc_cnt1 got cnt=%0d v=%b exp 1 0", dut.discard_cnt, ms_to_ws_valid); end
        tick();
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0BAD; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL disc_stale_dropped got %b exp 0", ms_to_ws_valid); end
        tick();
        data_sram_rdata = 32'hCAFE_F00D; #1;
        n_checks++; if (dut.discard_cnt !== 2'd0) begin n_fail++; $display("FAIL disc_cnt0 got %0d exp 0", dut.discard_cnt); end
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ws_s.final_result !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL disc_own_resp got v=%b %h exp 1 cafef00d", ms_to_ws_valid, ws_s.final_result); end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_store();
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1002, 5'd0);
        tick();
        es_to_ms_valid = 1'b0; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ms_ex_int !== 1'b1) begin n_fail++; $display("FAIL st_exc got v=%b ex=%b exp 1 1", ms_to_ws_valid, ms_ex_int); end
        n_checks++; if (ws_s.final_result !== 32'h1002 || ws_s.exc.mem !== 1'b1 || ds_s.we !== 1'b0) begin n_fail++; $display("FAIL st_exc_bus got %h mem=%b we=%b exp 1002 1 0", ws_s.final_result, ws_s.exc.mem, ds_s.we); end
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000, 5'd0);
        tick();
        es_to_ms_valid = 1'b0; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b0 || ms_ex_int !== 1'b0) begin n_fail++; $display("FAIL st_wait got v=%b ex=%b exp 0 0", ms_to_ws_valid, ms_ex_int); end
        data_sram_data_ok = 1'b1; #1;
        n_checks++; if (ms_to_ws_valid !== 1'b1 || ws_s.final_result !== 32'h1000) begin n_fail++; $display("FAIL st_release got v=%b %h exp 1 1000", ms_to_ws_valid, ws_s.final_result); end
        tick();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
        es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5000, 5'd6);
        tick();
        es_to_ms_valid = 1'b0; ws_block = 1'b1;
        tick();
        ws_block = 1'b0; es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5004, 5'd6);
        tick();
        es_to_ms_valid = 1'b0; ws_block = 1'b1;
        tick();
        ws_block = 1'b0; es_to_ms_valid = 1'b1; es_to_ms_bus = mk_inst(5'b00001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5008, 5'd6);
        tick();
        es_to_ms_valid = 1'b0; #1;
        n_checks++; if (dut.discard_cnt !== 2'd2 || ms_ex_int !== 1'b1 || ms_to_ws_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_pre got cnt=%0d ex=%b v=%b exp 2 1 0", dut.discard_cnt, ms_ex_int, ms_to_ws_valid); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1; #1;
        n_checks++; if (dut.ms_valid !== 1'b0 || dut.discard_cnt !== 2'd0 || ms_ex_int !== 1'b0) begin n_fail++; $display("FAIL rmid_post got v=%b cnt=%0d ex=%b exp 0 0 0", dut.ms_valid, dut.discard_cnt, ms_ex_int); end
    endtask

    initial begin
        test_reset();
        test_ld_w();
        test_ld_align();
        test_back_to_back();
        test_buffer();
        test_discard();
        test_store();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
